// File: rtl/pwm_ramp_ctrl.sv
// PWM duty ramp sequencer: programs period, walks duty from START to TARGET
// in STEP increments spaced INTERVAL+2 cycles apart, then leaves PWM enabled.
module pwm_ramp_ctrl #(
    parameter logic [3:0] PWM_PERIOD_ADDR = 4'h0,
    parameter logic [3:0] PWM_DUTY_ADDR   = 4'h4,
    parameter logic [3:0] PWM_EN_ADDR     = 4'h8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wen,
    input  logic [3:0] addr,
    input  logic [7:0] wdata,
    output logic       pwm_wen,
    output logic [3:0] pwm_addr,
    output logic [7:0] pwm_wdata,
    output logic       busy,
    output logic       done
);

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;

    localparam logic [AW-1:0] ADDR_PERIOD   = 4'h0;
    localparam logic [AW-1:0] ADDR_START    = 4'h1;
    localparam logic [AW-1:0] ADDR_TARGET   = 4'h2;
    localparam logic [AW-1:0] ADDR_STEP     = 4'h3;
    localparam logic [AW-1:0] ADDR_INTERVAL = 4'h4;
    localparam logic [AW-1:0] ADDR_CTRL     = 4'h5;

    typedef enum logic [2:0] {
        IDLE,
        W_PER,
        W_DUTY,
        W_EN,
        WAIT,
        W_STEP,
        FIN,
        W_OFF
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] period_r, start_r, target_r, step_r, interval_r;
    logic [DW-1:0] cur, cur_nxt;
    logic [DW-1:0] cnt, cnt_nxt;
    logic          pwm_wen_nxt;
    logic [AW-1:0] pwm_addr_nxt;
    logic [DW-1:0] pwm_wdata_nxt;

    logic          ctrl_wr, go, abort;
    logic [DW-1:0] step_eff, step_next;
    logic [DW:0]   sum9, diff9;

    assign ctrl_wr = wen && (addr == ADDR_CTRL);
    assign abort   = ctrl_wr && wdata[1];
    assign go      = ctrl_wr && wdata[0] && !wdata[1];

    // Next duty value: move toward TARGET by STEP (0 means 1), saturating at TARGET
    always_comb begin
        step_eff  = (step_r == '0) ? DW'(1) : step_r;
        sum9      = {1'b0, cur} + {1'b0, step_eff};
        diff9     = {1'b0, cur} - {1'b0, step_eff};
        step_next = target_r;
        if (cur < target_r) begin
            if (sum9 <= {1'b0, target_r}) step_next = sum9[DW-1:0];
        end else begin
            if (!diff9[DW] && (diff9[DW-1:0] >= target_r)) step_next = diff9[DW-1:0];
        end
    end

    // Host register file; only writable while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            period_r   <= '0;
            start_r    <= '0;
            target_r   <= '0;
            step_r     <= DW'(1);
            interval_r <= '0;
        end else if (wen && (state == IDLE)) begin
            case (addr)
                ADDR_PERIOD:   period_r   <= wdata;
                ADDR_START:    start_r    <= wdata;
                ADDR_TARGET:   target_r   <= wdata;
                ADDR_STEP:     step_r     <= wdata;
                ADDR_INTERVAL: interval_r <= wdata;
                default: ;
            endcase
        end
    end

    // Next-state, datapath and bus decode; bus values follow the next state so outputs register with it
    always_comb begin
        state_nxt     = state;
        cur_nxt       = cur;
        cnt_nxt       = cnt;
        pwm_wen_nxt   = 1'b0;
        pwm_addr_nxt  = '0;
        pwm_wdata_nxt = '0;

        case (state)
            IDLE: begin
                if (abort) begin
                    state_nxt = W_OFF;
                end else if (go) begin
                    state_nxt = W_PER;
                    cur_nxt   = start_r;
                end
            end
            W_PER:  state_nxt = W_DUTY;
            W_DUTY: state_nxt = W_EN;
            W_EN, W_STEP: begin
                if (cur == target_r) begin
                    state_nxt = FIN;
                end else begin
                    state_nxt = WAIT;
                    cnt_nxt   = interval_r;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = W_STEP;
                    cur_nxt   = step_next;
                end else begin
                    cnt_nxt = cnt - DW'(1);
                end
            end
            FIN:     state_nxt = IDLE;
            W_OFF:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (abort && (state != IDLE) && (state != W_OFF)) begin
            state_nxt = W_OFF;
            cur_nxt   = cur;
            cnt_nxt   = cnt;
        end

        case (state_nxt)
            W_PER: begin
                pwm_wen_nxt   = 1'b1;
                pwm_addr_nxt  = PWM_PERIOD_ADDR;
                pwm_wdata_nxt = period_r;
            end
            W_DUTY, W_STEP: begin
                pwm_wen_nxt   = 1'b1;
                pwm_addr_nxt  = PWM_DUTY_ADDR;
                pwm_wdata_nxt = cur_nxt;
            end
            W_EN: begin
                pwm_wen_nxt   = 1'b1;
                pwm_addr_nxt  = PWM_EN_ADDR;
                pwm_wdata_nxt = DW'(1);
            end
            W_OFF: begin
                pwm_wen_nxt   = 1'b1;
                pwm_addr_nxt  = PWM_EN_ADDR;
                pwm_wdata_nxt = '0;
            end
            default: ;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= '0;
            cnt       <= '0;
            pwm_wen   <= 1'b0;
            pwm_addr  <= '0;
            pwm_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur       <= cur_nxt;
            cnt       <= cnt_nxt;
            pwm_wen   <= pwm_wen_nxt;
            pwm_addr  <= pwm_addr_nxt;
            pwm_wdata <= pwm_wdata_nxt;
            busy      <= (state_nxt != IDLE);
            done      <= (state_nxt == FIN);
        end
    end

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter PWM_PERIOD_ADDR, default 4'h0, the PWM period register address.
REQ-002 SHALL have parameter PWM_DUTY_ADDR, default 4'h4, the PWM duty register address.
REQ-003 SHALL have parameter PWM_EN_ADDR, default 4'h8, the PWM enable register address.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port wen, input, 1 bit: host register write strobe, sampled each clk edge.
REQ-007 SHALL have port addr, input, 4 bits: host register address.
REQ-008 SHALL have port wdata, input, 8 bits: host write data.
REQ-009 SHALL have port pwm_wen, output, 1 bit: write strobe to the PWM core.
REQ-010 SHALL have port pwm_addr, output, 4 bits: PWM register address.
REQ-011 SHALL have port pwm_wdata, output, 8 bits: PWM write data.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when a ramp completes.

Function
REQ-014 SHALL decode these host registers: 0x0 PERIOD, 0x1 START, 0x2 TARGET, 0x3 STEP, 0x4 INTERVAL, 0x5 CTRL (bit0 go, bit1 abort; both self-clearing, not stored); other addresses ignored.
REQ-015 SHALL ignore host writes to 0x0-0x4 while busy; writes in IDLE take effect on the next edge.
REQ-016 SHALL treat STEP==0 as a step of 1.
REQ-017 SHALL implement states IDLE, W_PER, W_DUTY, W_EN, WAIT, W_STEP, FIN, W_OFF.
REQ-018 SHALL leave IDLE for W_PER on the edge sampling a CTRL write with go=1 and abort=0; go while busy is ignored.
REQ-019 SHALL, in W_PER, drive pwm_wen=1, pwm_addr=PWM_PERIOD_ADDR, pwm_wdata=PERIOD, and load cur=START.
REQ-020 SHALL, in W_DUTY, write cur to PWM_DUTY_ADDR; in W_EN, write 8'd1 to PWM_EN_ADDR.
REQ-021 SHALL, from W_EN, go to FIN if cur==TARGET; otherwise go to WAIT with the counter loaded to INTERVAL.
REQ-022 SHALL hold WAIT for INTERVAL+1 cycles, so consecutive duty writes are exactly INTERVAL+2 cycles apart, then go to W_STEP.
REQ-023 SHALL, in W_STEP, compute next in 9 bits as min(cur+STEP, TARGET) when cur<TARGET, else max(cur-STEP, TARGET); write next to PWM_DUTY_ADDR; set cur=next.
REQ-024 SHALL leave W_STEP for FIN when next==TARGET, else for WAIT.
REQ-025 SHALL assert done=1 for exactly the FIN cycle, then return to IDLE with the PWM left enabled.
REQ-026 SHALL, on a CTRL write with abort=1 in any busy state except W_OFF, go to W_OFF on the next edge; a write already in progress that cycle still completes.
REQ-027 SHALL, in W_OFF, write 8'd0 to PWM_EN_ADDR, then go to IDLE without pulsing done.
REQ-028 SHALL give abort priority over go when both bits are set; in IDLE this issues the W_OFF write.
REQ-029 SHALL drive pwm_wen=0 and pwm_addr/pwm_wdata=0 in IDLE, WAIT, and FIN.

Reset
REQ-030 SHALL, on rst=1 at a clk edge, enter IDLE and clear pwm_wen, pwm_addr, pwm_wdata, busy, done, cur, and the counter.
REQ-031 SHALL reset PERIOD, START, TARGET, and INTERVAL to 0 and STEP to 1.
REQ-032 SHALL let rst mid-ramp abandon the sequence with no W_OFF write; rst overrides a simultaneous host write.

Verification
REQ-033 SHALL cover an up ramp: PERIOD=100, START=10, TARGET=40, STEP=10, INTERVAL=3, go sampled at edge 0 -> period 100 at cycle 1, duty 10 at c2, enable 1 at c3, duty 20/30/40 at c8/c13/c18, done at c19, busy=0 at c20.
REQ-034 SHALL cover a down ramp with saturation: START=50, TARGET=5, STEP=20, INTERVAL=0 -> duty 50, then 30, 10, 5 spaced 2 cycles apart, then done.
REQ-035 SHALL cover START==TARGET=25 -> three writes (period, 25, enable) then done the cycle after W_EN, with no WAIT.
REQ-036 SHALL cover abort during WAIT -> next cycle pwm_wen=1, addr 0x8, data 0; then IDLE, done never asserted.
REQ-037 SHALL cover a TARGET write while busy and a second go while busy -> both ignored and the ramp ends at the original target; STEP=0 steps by 1.
REQ-038 SHALL cover rst asserted at c10 of the REQ-033 run -> all outputs 0 at c11; the registers hold reset values.
